// File: rtl/axil_uart_pkg.sv
// axil_uart_pkg: shared constants and state encodings for the AXI4-Lite UART.
//   - register offsets (decoded from addr[3:0])
//   - AXI response codes
//   - STATUS register bit positions
//   - TX / RX state machine encodings
package axil_uart_pkg;

  localparam logic [3:0] ADDR_TXDATA = 4'h0;
  localparam logic [3:0] ADDR_RXDATA = 4'h4;
  localparam logic [3:0] ADDR_STATUS = 4'h8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;
  localparam int ST_TX_BUSY    = 5;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // RX_BREAK holds off after a framing error until the line returns high,
  // so a long break is not mistaken for a new start bit.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Only the three aligned offsets are mapped; any other value (including
  // unaligned ones) answers SLVERR.
  function automatic logic addr_ok(input logic [3:0] a);
    return (a == ADDR_TXDATA) || (a == ADDR_RXDATA) || (a == ADDR_STATUS);
  endfunction

endpackage

// File: rtl/axil_uart_if.sv
// axil_uart_if: AXI4-Lite bus bundle between the interconnect and the UART.
//   write address : awaddr, awvalid, awready
//   write data    : wdata, wstrb, wvalid, wready
//   write resp    : bresp, bvalid, bready
//   read address  : araddr, arvalid, arready
//   read data     : rdata, rresp, rvalid, rready
// master modport drives requests, slave modport drives responses.
interface axil_uart_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_uart_sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead output.
//   clk, rst      : clock, async active-high reset (empties the FIFO)
//   push, din     : write request and data; ignored when full unless a pop
//                   frees a slot in the same cycle
//   pop, dout     : read request; dout always shows the oldest entry
//   full, empty   : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axil_uart.sv
// axil_uart: AXI4-Lite slave UART (8N1) with TX FIFO and single RX holding reg.
//   clk, rst : clock, async active-high reset
//   bus      : AXI4-Lite slave port (axil_uart_if.slave)
//   rx       : serial input, asynchronous to clk
//   tx       : serial output, idle high
// Registers (addr[3:0]): 0x0 TXDATA (W), 0x4 RXDATA (R), 0x8 STATUS (R/W1C).
//
// TX states                      | RX states
//   TX_IDLE  | line high, wait   |   RX_IDLE  | wait for low level
//   TX_START | drive start bit   |   RX_START | half-bit glitch filter
//   TX_DATA  | shift 8 bits LSB  |   RX_DATA  | 8 mid-bit samples, LSB first
//   TX_STOP  | drive stop bit    |   RX_STOP  | stop-bit check, commit
//                                |   RX_BREAK | framing error, wait for high
module axil_uart
  import axil_uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200,
  parameter int TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  axil_uart_if.slave  bus,
  input  logic        rx,
  output logic        tx
);

  localparam int DIV_RAW = CLK_FREQ / BAUD;
  localparam int DIV     = (DIV_RAW < 4) ? 4 : DIV_RAW;
  localparam int CNT_W   = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);

  // ---------------------------------------------------------------- bus side
  logic        aw_rdy, ar_rdy;
  logic        bvalid_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q, rd_val;
  logic        wr_hs, rd_hs;
  logic [3:0]  wr_addr, rd_addr;
  logic        fifo_push, clr_ovr, clr_ferr, rd_rx;
  logic [5:0]  status;

  logic        fifo_full, fifo_empty, tx_pop;
  logic [7:0]  fifo_dout;
  logic        rx_valid, rx_ovr, rx_ferr;
  logic [7:0]  rx_byte;
  logic        tx_busy;

  assign bus.awready = aw_rdy;
  assign bus.wready  = aw_rdy;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = ar_rdy;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;

  assign wr_addr = bus.awaddr[3:0];
  assign rd_addr = bus.araddr[3:0];
  assign wr_hs   = aw_rdy & bus.awvalid & bus.wvalid;
  assign rd_hs   = ar_rdy & bus.arvalid;

  assign fifo_push = wr_hs & (wr_addr == ADDR_TXDATA) & bus.wstrb[0];
  assign clr_ovr   = wr_hs & (wr_addr == ADDR_STATUS) & bus.wstrb[0] & bus.wdata[ST_RX_OVERRUN];
  assign clr_ferr  = wr_hs & (wr_addr == ADDR_STATUS) & bus.wstrb[0] & bus.wdata[ST_FRAME_ERR];
  assign rd_rx     = rd_hs & (rd_addr == ADDR_RXDATA);

  logic unused_bits;
  assign unused_bits = ^{bus.awaddr[31:4], bus.araddr[31:4], bus.wdata[31:8], bus.wstrb[3:1]};

  // awready/wready pulse once both channels are presented; bvalid follows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_rdy   <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      aw_rdy <= bus.awvalid & bus.wvalid & ~bvalid_q & ~aw_rdy;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= addr_ok(wr_addr) ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q & bus.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign status[ST_TX_FULL]    = fifo_full;
  assign status[ST_TX_EMPTY]   = fifo_empty;
  assign status[ST_RX_VALID]   = rx_valid;
  assign status[ST_RX_OVERRUN] = rx_ovr;
  assign status[ST_FRAME_ERR]  = rx_ferr;
  assign status[ST_TX_BUSY]    = tx_busy;

  always_comb begin
    rd_val = '0;
    case (rd_addr)
      ADDR_RXDATA: rd_val = {rx_valid, 23'b0, rx_byte};
      ADDR_STATUS: rd_val = {26'b0, status};
      default:     ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_rdy   <= 1'b0;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      ar_rdy <= bus.arvalid & ~rvalid_q & ~ar_rdy;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
        rresp_q  <= addr_ok(rd_addr) ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q & bus.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- TX path
  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (bus.wdata[7:0]),
    .pop   (tx_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  tx_state_t        tx_state, tx_next;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_idx;
  logic [7:0]       tx_sh;
  logic             tx_tc, tx_d, tx_q;

  assign tx_tc   = (tx_cnt == '0);
  assign tx_busy = (tx_state != TX_IDLE);
  assign tx      = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (!fifo_empty) tx_next = TX_START;
      TX_START: if (tx_tc) tx_next = TX_DATA;
      TX_DATA:  if (tx_tc && tx_idx == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tc) tx_next = fifo_empty ? TX_IDLE : TX_START;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // A pop at the end of STOP chains straight into the next START.
  always_comb begin
    tx_pop = 1'b0;
    tx_d   = 1'b1;
    case (tx_state)
      TX_IDLE:  tx_pop = ~fifo_empty;
      TX_START: tx_d   = 1'b0;
      TX_DATA:  tx_d   = tx_sh[0];
      TX_STOP:  tx_pop = tx_tc & ~fifo_empty;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
      tx_q   <= 1'b1;
    end else begin
      tx_q <= tx_d;
      if (tx_pop) begin
        tx_sh  <= fifo_dout;
        tx_cnt <= CNT_BIT;
        tx_idx <= '0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_tc) begin
          tx_cnt <= CNT_BIT;
          if (tx_state == TX_DATA) begin
            tx_sh  <= tx_sh >> 1;
            tx_idx <= tx_idx + 3'd1;
          end
        end else begin
          tx_cnt <= tx_cnt - CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------- RX path
  logic             rx_meta, rx_s;
  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_sh;
  logic             rx_tc, rx_sample, rx_commit, rx_ferr_set;

  assign rx_tc = (rx_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_s) rx_next = RX_START;
      RX_START: if (rx_tc) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tc && rx_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tc) rx_next = rx_s ? RX_IDLE : RX_BREAK;
      RX_BREAK: if (rx_s) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_sample   = 1'b0;
    rx_commit   = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state)
      RX_DATA: rx_sample   = rx_tc;
      RX_STOP: begin
        rx_commit   = rx_tc & rx_s;
        rx_ferr_set = rx_tc & ~rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh  <= '0;
    end else begin
      case (rx_state)
        RX_START, RX_DATA, RX_STOP: rx_cnt <= rx_tc ? CNT_BIT : rx_cnt - CNT_W'(1);
        default: begin
          rx_cnt <= CNT_HALF;
          rx_idx <= '0;
        end
      endcase
      if (rx_sample) begin
        rx_sh  <= {rx_s, rx_sh[7:1]};
        rx_idx <= rx_idx + 3'd1;
      end
    end
  end

  // A commit in the same cycle as an RXDATA read hands the old byte to the
  // reader and keeps the new one valid, so it does not count as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      rx_ovr   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      if (rx_commit) begin
        rx_byte  <= rx_sh;
        rx_valid <= 1'b1;
      end else if (rd_rx) begin
        rx_valid <= 1'b0;
      end
      if (rx_commit && rx_valid && !rd_rx) rx_ovr <= 1'b1;
      else if (clr_ovr)                    rx_ovr <= 1'b0;
      if (rx_ferr_set)   rx_ferr <= 1'b1;
      else if (clr_ferr) rx_ferr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_uart.sv
// tb_axil_uart: self-checking bench for axil_uart at DIV=10.
// TX bytes and read responses are queued when stimulus is issued and
// compared when the serial frame / read response appears.
module tb_axil_uart;
  import axil_uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  axil_uart_if bus();

  axil_uart #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000),
    .TX_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .rx  (rx),
    .tx  (tx)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0]  tx_exp[$];
  logic [33:0] rd_q[$];
  int          starts[$];
  bit          mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Serial monitor: detects a start edge, samples mid-bit, pops the expected byte.
  initial begin
    logic [7:0]  mb;
    logic [31:0] me;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && tx == 1'b0) begin
        starts.push_back(cyc);
        repeat (5) @(negedge clk);
        check("tx_start_bit", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          mb[i] = tx;
        end
        repeat (10) @(negedge clk);
        check("tx_stop_bit", tx, 1);
        if (tx_exp.size() != 0) me = {24'h0, tx_exp.pop_front()};
        else                    me = 32'h100;
        check("tx_byte", {24'h0, mb}, me);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.awaddr  = {28'h0, addr};
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.awready && n < 20);
    check("awready", bus.awready, 1);
    check("wready", bus.wready, 1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("aw_pulse", bus.awready, 0);
    check("bvalid", bus.bvalid, 1);
    check("bresp", bus.bresp, resp);
    @(negedge clk);
    check("bvalid_hold", bus.bvalid, 1);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("bvalid_clr", bus.bvalid, 0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] data, input logic [1:0] resp);
    logic [33:0] e;
    int n;
    rd_q.push_back({resp, data});
    @(negedge clk);
    bus.araddr  = {28'h0, addr};
    bus.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.arready && n < 20);
    check("arready", bus.arready, 1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("rvalid", bus.rvalid, 1);
    e = rd_q.pop_front();
    check("rdata", bus.rdata, e[31:0]);
    check("rresp", {30'h0, bus.rresp}, {30'h0, e[33:32]});
    @(negedge clk);
    check("rdata_hold", bus.rdata, e[31:0]);
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    check("rvalid_clr", bus.rvalid, 0);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = stop;
    repeat (10) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_tx_done();
    int n;
    n = 0;
    while (tx_exp.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    check("tx_drain", tx_exp.size(), 0);
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int n, lows;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_bresp", {30'h0, bus.bresp}, 0);
    check("rst_rresp", {30'h0, bus.rresp}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    axi_read(ADDR_STATUS, 32'h02, RESP_OKAY);

    // single byte
    tx_exp.push_back(8'h55);
    axi_write(ADDR_TXDATA, 32'h55, 4'h1, RESP_OKAY);
    wait_tx_done();
    axi_read(ADDR_STATUS, 32'h02, RESP_OKAY);

    // back-to-back burst, FIFO full drop, strobe-less write ignored
    starts.delete();
    for (int i = 1; i <= 5; i++) begin
      tx_exp.push_back(8'(i));
      axi_write(ADDR_TXDATA, 32'(i), 4'h1, RESP_OKAY);
    end
    axi_write(ADDR_TXDATA, 32'h66, 4'h1, RESP_OKAY);
    axi_read(ADDR_STATUS, 32'h21, RESP_OKAY);
    axi_write(ADDR_TXDATA, 32'h77, 4'h0, RESP_OKAY);
    wait_tx_done();
    repeat (150) @(negedge clk);
    check("burst_frames", starts.size(), 5);
    for (int i = 1; i < 5 && i < starts.size(); i++)
      check("burst_gap", starts[i] - starts[i-1], 100);
    axi_read(ADDR_STATUS, 32'h02, RESP_OKAY);

    // receive
    send_rx(8'hA3, 1'b1);
    repeat (5) @(negedge clk);
    axi_read(ADDR_STATUS, 32'h06, RESP_OKAY);
    axi_read(ADDR_RXDATA, 32'h8000_00A3, RESP_OKAY);
    axi_read(ADDR_RXDATA, 32'h0000_00A3, RESP_OKAY);

    // overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (5) @(negedge clk);
    axi_read(ADDR_STATUS, 32'h0E, RESP_OKAY);
    axi_read(ADDR_RXDATA, 32'h8000_0022, RESP_OKAY);
    axi_write(ADDR_STATUS, 32'h08, 4'h1, RESP_OKAY);
    axi_read(ADDR_STATUS, 32'h02, RESP_OKAY);

    // framing error, then glitch
    send_rx(8'h00, 1'b0);
    repeat (5) @(negedge clk);
    axi_read(ADDR_STATUS, 32'h12, RESP_OKAY);
    axi_write(ADDR_STATUS, 32'h10, 4'h1, RESP_OKAY);
    axi_read(ADDR_STATUS, 32'h02, RESP_OKAY);
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    axi_read(ADDR_STATUS, 32'h02, RESP_OKAY);
    axi_read(ADDR_RXDATA, 32'h0000_0022, RESP_OKAY);

    // decode errors and unmapped accesses
    axi_read(4'hC, 32'h0, RESP_SLVERR);
    axi_read(4'h2, 32'h0, RESP_SLVERR);
    axi_write(4'hC, 32'h55, 4'h1, RESP_SLVERR);
    axi_write(4'h2, 32'h99, 4'h1, RESP_SLVERR);
    axi_write(ADDR_RXDATA, 32'h5A, 4'h1, RESP_OKAY);
    axi_read(ADDR_TXDATA, 32'h0, RESP_OKAY);
    repeat (120) @(negedge clk);
    axi_read(ADDR_STATUS, 32'h02, RESP_OKAY);

    // reset in the middle of a frame
    mon_en = 1'b0;
    axi_write(ADDR_TXDATA, 32'h5A, 4'h1, RESP_OKAY);
    axi_write(ADDR_TXDATA, 32'h11, 4'h1, RESP_OKAY);
    axi_write(ADDR_TXDATA, 32'h22, 4'h1, RESP_OKAY);
    n = 0;
    while (tx !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check("pre_rst_tx_low", tx, 0);
    rst = 1'b1;
    #1;
    check("rst_async_tx", tx, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    axi_read(ADDR_STATUS, 32'h02, RESP_OKAY);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx == 1'b0) lows++;
    end
    check("post_rst_tx_idle", lows, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
